// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter and sequencer sharing SRAM port B between two requesters.
// Each access runs IDLE -> ACCESS -> DONE, with a bounded wait for sram_ack.
module sram_port_arbiter #(
    parameter int AW      = 13,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0,
    input  logic            req1,
    input  logic            wen0,
    input  logic            wen1,
    input  logic [AW-1:0]   addr0,
    input  logic [AW-1:0]   addr1,
    input  logic [DW-1:0]   din0,
    input  logic [DW-1:0]   din1,
    input  logic [DW/8-1:0] be0,
    input  logic [DW/8-1:0] be1,
    output logic            ack0,
    output logic            ack1,
    output logic            err,
    output logic [DW-1:0]   rdata,
    output logic            sram_cen,
    output logic            sram_wen,
    output logic [AW-1:0]   sram_addr,
    output logic [DW-1:0]   sram_din,
    output logic [DW/8-1:0] sram_be,
    input  logic [DW-1:0]   sram_dout,
    input  logic            sram_ack,
    output logic [1:0]      dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    // Timeout fires on the edge where the counter would step from TIMEOUT-1 to TIMEOUT.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t            state_q, state_n;
    logic              last_grant_q, last_grant_n;
    logic              grant_q, grant_n;
    logic [7:0]        cnt_q, cnt_n;
    logic              ack0_n, ack1_n, err_n;
    logic [DW-1:0]     rdata_n;
    logic              cen_n, wen_n;
    logic [AW-1:0]     addr_n;
    logic [DW-1:0]     din_n;
    logic [DW/8-1:0]   be_n;
    logic              win1;

    // Handshake: a requester holds req (and its operands) high until its one-cycle
    // ack; err qualifies that ack. Operands are sampled only on the grant edge.
    assign win1      = req1 & (~req0 | ~last_grant_q);
    assign dbg_state = state_q;

    always_comb begin
        state_n      = state_q;
        last_grant_n = last_grant_q;
        grant_n      = grant_q;
        cnt_n        = cnt_q;
        ack0_n       = 1'b0;
        ack1_n       = 1'b0;
        err_n        = err;
        rdata_n      = rdata;
        cen_n        = sram_cen;
        wen_n        = sram_wen;
        addr_n       = sram_addr;
        din_n        = sram_din;
        be_n         = sram_be;

        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    grant_n      = win1;
                    last_grant_n = win1;
                    wen_n        = win1 ? wen1  : wen0;
                    addr_n       = win1 ? addr1 : addr0;
                    din_n        = win1 ? din1  : din0;
                    be_n         = win1 ? be1   : be0;
                    cen_n        = 1'b0;
                    cnt_n        = 8'd0;
                    state_n      = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (sram_ack || cnt_q == CNT_LAST) begin
                    err_n   = ~sram_ack;
                    rdata_n = sram_ack ? sram_dout : '0;
                    ack0_n  = ~grant_q;
                    ack1_n  = grant_q;
                    cen_n   = 1'b1;
                    wen_n   = 1'b1;
                    state_n = S_DONE;
                end else begin
                    cnt_n = cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            cnt_q        <= 8'd0;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            err          <= 1'b0;
            rdata        <= '0;
            sram_cen     <= 1'b1;
            sram_wen     <= 1'b1;
            sram_addr    <= '0;
            sram_din     <= '0;
            sram_be      <= '0;
        end else begin
            state_q      <= state_n;
            last_grant_q <= last_grant_n;
            grant_q      <= grant_n;
            cnt_q        <= cnt_n;
            ack0         <= ack0_n;
            ack1         <= ack1_n;
            err          <= err_n;
            rdata        <= rdata_n;
            sram_cen     <= cen_n;
            sram_wen     <= wen_n;
            sram_addr    <= addr_n;
            sram_din     <= din_n;
            sram_be      <= be_n;
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: each task drives one scenario and
// checks outputs 1 time unit after the rising edge.
module tb_sram_port_arbiter;

    localparam int AW = 13;
    localparam int DW = 32;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, req1, wen0, wen1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] din0, din1;
    logic [3:0]    be0, be1;
    logic          ack0, ack1, err;
    logic [DW-1:0] rdata;
    logic          sram_cen, sram_wen;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din;
    logic [3:0]    sram_be;
    logic [DW-1:0] sram_dout;
    logic          sram_ack;
    logic [1:0]    dbg_state;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    sram_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .wen0(wen0), .wen1(wen1),
        .addr0(addr0), .addr1(addr1), .din0(din0), .din1(din1),
        .be0(be0), .be1(be1),
        .ack0(ack0), .ack1(ack1), .err(err), .rdata(rdata),
        .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_addr(sram_addr),
        .sram_din(sram_din), .sram_be(sram_be),
        .sram_dout(sram_dout), .sram_ack(sram_ack),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b1; req0 = 0; req1 = 0; wen0 = 1; wen1 = 1;
        addr0 = '0; addr1 = '0; din0 = '0; din1 = '0; be0 = '0; be1 = '0;
        sram_dout = '0; sram_ack = 0;
        tick(); tick();
        total++; if ({sram_cen, sram_wen} !== 2'b11) begin bad++; $display("FAIL reset_cen_wen got=%b exp=11", {sram_cen, sram_wen}); end
        total++; if ({ack0, ack1, err} !== 3'b000) begin bad++; $display("FAIL reset_ack_err got=%b exp=000", {ack0, ack1, err}); end
        total++; if (sram_addr !== '0 || sram_din !== '0 || sram_be !== '0 || rdata !== '0) begin
            bad++; $display("FAIL reset_data addr=%h din=%h be=%h rdata=%h exp=0", sram_addr, sram_din, sram_be, rdata); end
        total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_read();
        req0 = 1; wen0 = 1; addr0 = 13'h010;
        tick();
        total++; if ({sram_cen, sram_wen, sram_addr} !== {1'b0, 1'b1, 13'h010}) begin
            bad++; $display("FAIL read_issue cen=%b wen=%b addr=%h exp cen=0 wen=1 addr=010", sram_cen, sram_wen, sram_addr); end
        tick();
        total++; if (ack0 !== 1'b0) begin bad++; $display("FAIL read_early_ack got=%b exp=0", ack0); end
        sram_ack = 1; sram_dout = 32'h4;
        tick();
        total++; if ({ack0, ack1, err, rdata} !== {3'b100, 32'h4}) begin
            bad++; $display("FAIL read_ack ack0=%b ack1=%b err=%b rdata=%h exp 1 0 0 00000004", ack0, ack1, err, rdata); end
        total++; if ({sram_cen, sram_wen} !== 2'b11) begin bad++; $display("FAIL read_done_cen got=%b exp=11", {sram_cen, sram_wen}); end
        sram_ack = 0; req0 = 0;
        tick();
        total++; if (ack0 !== 1'b0 || dbg_state !== 2'd0) begin
            bad++; $display("FAIL read_ack_width ack0=%b state=%0d exp 0 0", ack0, dbg_state); end
    endtask

    task automatic test_half_write();
        req1 = 1; wen1 = 0; addr1 = 13'h032; din1 = 32'h5555_5555; be1 = 4'b1100;
        tick();
        total++; if ({sram_cen, sram_wen, sram_be, sram_addr, sram_din} !== {1'b0, 1'b0, 4'b1100, 13'h032, 32'h5555_5555}) begin
            bad++; $display("FAIL write_issue cen=%b wen=%b be=%b addr=%h din=%h", sram_cen, sram_wen, sram_be, sram_addr, sram_din); end
        sram_ack = 1; sram_dout = 32'hDEAD_BEEF;
        tick();
        total++; if ({ack0, ack1, err} !== 3'b010) begin
            bad++; $display("FAIL write_ack got ack0/ack1/err=%b exp=010", {ack0, ack1, err}); end
        sram_ack = 0; req1 = 0; wen1 = 1;
        tick();
        total++; if ({ack0, ack1} !== 2'b00) begin bad++; $display("FAIL write_ack_width got=%b exp=00", {ack0, ack1}); end
    endtask

    task automatic test_tie();
        int exp_g, n, start, prev_start;
        rst = 1; tick(); rst = 0;
        req0 = 1; req1 = 1; wen0 = 1; wen1 = 1; addr0 = 13'h040; addr1 = 13'h080;
        prev_start = 0;
        for (int i = 0; i < 4; i++) begin
            exp_g = i % 2;
            n = 0;
            while (sram_cen !== 1'b0 && n < 20) begin tick(); n++; end
            total++; if (n >= 20) begin bad++; $display("FAIL tie_wait_cen access=%0d got=timeout exp=cen low", i); end
            start = cyc;
            total++; if (sram_addr !== (exp_g == 1 ? 13'h080 : 13'h040)) begin
                bad++; $display("FAIL tie_grant access=%0d addr=%h exp grant %0d", i, sram_addr, exp_g); end
            if (i > 0) begin
                total++; if (start - prev_start < 3) begin bad++; $display("FAIL tie_spacing access=%0d got=%0d exp>=3", i, start - prev_start); end
            end
            prev_start = start;
            sram_ack = 1; sram_dout = DW'(i + 1);
            tick();
            sram_ack = 0;
            total++; if ({ack0, ack1} !== (exp_g == 1 ? 2'b01 : 2'b10) || rdata !== DW'(i + 1)) begin
                bad++; $display("FAIL tie_ack access=%0d ack0=%b ack1=%b rdata=%h exp grant %0d rdata %0h", i, ack0, ack1, rdata, exp_g, i + 1); end
            if (i == 3) begin req0 = 0; req1 = 0; end
            tick();
            total++; if ({ack0, ack1} !== 2'b00) begin bad++; $display("FAIL tie_ack_width access=%0d got=%b exp=00", i, {ack0, ack1}); end
        end
        tick();
    endtask

    task automatic test_timeout();
        req0 = 1; wen0 = 1; addr0 = 13'h100;
        tick();
        total++; if (sram_cen !== 1'b0) begin bad++; $display("FAIL to_issue cen=%b exp=0", sram_cen); end
        for (int j = 1; j < TO; j++) tick();
        total++; if (ack0 !== 1'b0) begin bad++; $display("FAIL to_early ack0=%b exp=0 at cycle %0d", ack0, TO - 1); end
        tick();
        total++; if ({ack0, err, rdata} !== {2'b11, 32'h0}) begin
            bad++; $display("FAIL to_abort ack0=%b err=%b rdata=%h exp 1 1 00000000", ack0, err, rdata); end
        req0 = 0;
        tick();
        sram_ack = 1; sram_dout = 32'h1234;
        tick();
        sram_ack = 0;
        total++; if ({ack0, ack1, err, sram_cen, rdata, dbg_state} !== {4'b0011, 32'h0, 2'd0}) begin
            bad++; $display("FAIL to_stray ack0=%b ack1=%b err=%b cen=%b rdata=%h state=%0d exp 0 0 1 1 0 0",
                            ack0, ack1, err, sram_cen, rdata, dbg_state); end
        tick();
    endtask

    task automatic test_ack_at_timeout();
        req0 = 1; wen0 = 1; addr0 = 13'h104;
        tick();
        for (int j = 1; j < TO; j++) tick();
        sram_ack = 1; sram_dout = 32'hAAAA;
        tick();
        sram_ack = 0;
        total++; if ({ack0, err, rdata} !== {2'b10, 32'hAAAA}) begin
            bad++; $display("FAIL ack_at_to ack0=%b err=%b rdata=%h exp 1 0 0000aaaa", ack0, err, rdata); end
        req0 = 0;
        tick(); tick();
    endtask

    task automatic test_reset_mid_access();
        int n;
        req1 = 1; wen1 = 0; addr1 = 13'h0F0; din1 = 32'h1111_2222; be1 = 4'b1111;
        tick();
        tick();
        rst = 1;
        #1;
        total++; if ({sram_cen, sram_wen, ack0, ack1, err, sram_addr, dbg_state} !== {5'b11000, 13'h0, 2'd0}) begin
            bad++; $display("FAIL rst_mid cen=%b wen=%b ack0=%b ack1=%b err=%b addr=%h state=%0d exp 1 1 0 0 0 0 0",
                            sram_cen, sram_wen, ack0, ack1, err, sram_addr, dbg_state); end
        req1 = 0;
        tick();
        rst = 0;
        req1 = 1; wen1 = 1; addr1 = 13'h020;
        tick();
        total++; if ({sram_cen, sram_wen, sram_addr} !== {2'b01, 13'h020}) begin
            bad++; $display("FAIL rst_after_issue cen=%b wen=%b addr=%h exp 0 1 020", sram_cen, sram_wen, sram_addr); end
        sram_ack = 1; sram_dout = 32'h0BAD_F00D;
        n = 0;
        tick();
        sram_ack = 0;
        total++; if ({ack0, ack1, err, rdata} !== {3'b010, 32'h0BAD_F00D}) begin
            bad++; $display("FAIL rst_after_ack ack0=%b ack1=%b err=%b rdata=%h exp 0 1 0 0badf00d", ack0, ack1, err, rdata); end
        req1 = 0;
        tick(); tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_half_write();
        test_tie();
        test_timeout();
        test_ack_at_timeout();
        test_reset_mid_access();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
